dcache_data_array: RTL and testbench
====================================

# dcache_data_array

Parametrised, multi-way successor to the single-way D-cache data RAM. It holds `WAYS` ways of `SETS` lines, each `LINE_WORDS` 32-bit words. It serves three clients: a 1-cycle registered all-ways lookup read, a byte-strobed store, and two sequential line engines (refill from the bus, word by word; eviction read-out to the write-back path with a valid/ready handshake). It sits between the D-cache controller (tag/LRU/miss FSM) and the AXI bridge.

## Interface
- `WAYS`, 2: number of ways (power of 2, ≥1).
- `SET_BITS`, 7: index width; `SETS = 2**SET_BITS`.
- `OFF_BITS`, 3: word-offset width; `LINE_WORDS = 2**OFF_BITS`.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rd_en`, `rd_index[SET_BITS]`, `rd_off[OFF_BITS]` in: lookup request.
- `rd_data` out `WAYS*32`: way *w* at bits `[w*32 +: 32]`, registered.
- `st_en`, `st_way[$clog2(WAYS)]`, `st_index`, `st_off`, `st_strb[4]`, `st_wdata[32]` in: store; byte *b* written iff `st_strb[b]`.
- `fill_start`, `fill_way`, `fill_index` in: begin refill.
- `fill_valid` in 1, `fill_data` in 32, `fill_last` in 1: refill beat stream (no backpressure).
- `fill_done` out 1: one-cycle pulse after last refill beat written.
- `ev_start`, `ev_way`, `ev_index` in: begin eviction read-out.
- `ev_valid` out 1, `ev_data` out 32, `ev_last` out 1, `ev_ready` in 1: eviction stream.
- `busy` out 1: high in FILL or EVICT.

## Operation
- FSM states: IDLE, FILL, EVICT. Word counter `cnt[OFF_BITS]`; latched `way_q`, `index_q`.
- IDLE: `ev_start` has priority over `fill_start`. Either latches way/index, clears `cnt`, and moves to EVICT/FILL. Lookup and store are serviced in IDLE only; in other states they are ignored (controller must hold them off via `busy`).
- Lookup: `rd_data` ← all ways at `[rd_index][rd_off]` on the edge where `rd_en`=1; holds its value otherwise. Store and lookup to the same word in the same cycle: read-first (old data returned).
- Store: masked byte write to `[st_way][st_index][st_off]`; `st_strb`=0 is a no-op.
- FILL: each `fill_valid` beat writes a full word to `[way_q][index_q][cnt]` and increments `cnt`. The beat with `fill_last`=1, or the beat at `cnt`=LINE_WORDS-1 (whichever comes first), is the final beat. The final beat returns to IDLE and pulses `fill_done` next cycle. Words not reached keep their old contents.
- EVICT: `ev_valid`=1 and `ev_data` = word `[way_q][index_q][cnt]` (combinational array read). `ev_last` = (`cnt`==LINE_WORDS-1). On `ev_valid & ev_ready`, `cnt`++; the handshake with `ev_last` returns to IDLE. `ev_data` stays stable while `ev_ready`=0.
- Array contents are never cleared by reset.

## Timing
- Reset (async assert): state IDLE, `cnt`=0, `rd_data`=0, `fill_done`=0, `ev_valid`=0, `ev_last`=0, `busy`=0, `ev_data` don't-care. Reset mid-FILL/EVICT aborts immediately; a partially filled line keeps its written words.
- Lookup latency 1 cycle. Store is visible to a lookup issued the following cycle.
- `fill_start`→FILL: first beat accepted the cycle after start. Beats may arrive back-to-back, 1 per cycle. Min refill = LINE_WORDS cycles + 1 for `fill_done`.
- EVICT: `ev_valid` rises the cycle after `ev_start`. With `ev_ready` held high, 1 word per cycle, LINE_WORDS cycles.
- `busy` is registered: high from the cycle after start through the last beat/handshake cycle. New starts are accepted in the first IDLE cycle.
- Counter wraps naturally at LINE_WORDS. It never indexes past the line.

## Structure
- Shared package `dcache_pkg`: `WAYS`, `SET_BITS`, `OFF_BITS` defaults, `LINE_WORDS`, and the FSM state enum `dcache_arr_state_t`.
- One sub-module, `dcache_way_ram`: a single-way `SETS*LINE_WORDS × 32` array with byte-enable write port and async read port. Instantiated `WAYS` times via generate. Write-port select (store vs refill) and read-address select (lookup vs evict) are muxed in the top.

## Test plan
- Store 0xDEADBEEF strb 1111 to way1/set5/off2, then lookup set5/off2 → `rd_data[63:32]`=0xDEADBEEF one cycle later, way0 slice unchanged.
- Byte store strb 0100 data 0x00AB0000 over 0x11223344 → lookup returns 0x11AB3344. Same-cycle store+lookup returns 0x11223344.
- Refill way0/set3 with 8 back-to-back beats 0x100..0x107, `fill_last` on the 8th → `fill_done` pulses once, `busy` drops, lookups return 0x100+off.
- Evict way0/set3 with `ev_ready` toggling 1,0,1… → 8 handshakes in order 0x100..0x107, `ev_last` only on 0x107, `ev_data` stable during stalls.
- `ev_start` and `fill_start` in the same cycle → EVICT taken, fill ignored. Store during FILL → array unchanged.
- Assert `reset` low after 3 refill beats → outputs at reset values at once, IDLE. The 3 words remain, the rest keep their old data.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared defaults and FSM encoding for the multi-way D-cache data array.
package dcache_pkg;
  localparam int WAYS       = 2;
  localparam int SET_BITS   = 7;
  localparam int OFF_BITS   = 3;
  localparam int LINE_WORDS = 2 ** OFF_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_EVICT
  } dcache_arr_state_t;
endpackage

// File: rtl/dcache_data_array_way_ram.sv
// Single way of line storage: byte-enable write port, asynchronous read port.
module dcache_way_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           wstrb,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);
  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dcache_data_array.sv
// Multi-way D-cache data array: registered lookup, byte store, refill and eviction engines.
// state    | meaning
// ST_IDLE  | lookups/stores serviced, waiting for ev_start/fill_start
// ST_FILL  | writing refill beats into [way_q][index_q][cnt]
// ST_EVICT | streaming [way_q][index_q][cnt] out with valid/ready
module dcache_data_array #(
  parameter int WAYS     = dcache_pkg::WAYS,
  parameter int SET_BITS = dcache_pkg::SET_BITS,
  parameter int OFF_BITS = dcache_pkg::OFF_BITS,
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int ADDR_BITS = SET_BITS + OFF_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_en,
  input  logic [SET_BITS-1:0] rd_index,
  input  logic [OFF_BITS-1:0] rd_off,
  output logic [WAYS*32-1:0]  rd_data,
  input  logic                st_en,
  input  logic [WAY_BITS-1:0] st_way,
  input  logic [SET_BITS-1:0] st_index,
  input  logic [OFF_BITS-1:0] st_off,
  input  logic [3:0]          st_strb,
  input  logic [31:0]         st_wdata,
  input  logic                fill_start,
  input  logic [WAY_BITS-1:0] fill_way,
  input  logic [SET_BITS-1:0] fill_index,
  input  logic                fill_valid,
  input  logic [31:0]         fill_data,
  input  logic                fill_last,
  output logic                fill_done,
  input  logic                ev_start,
  input  logic [WAY_BITS-1:0] ev_way,
  input  logic [SET_BITS-1:0] ev_index,
  output logic                ev_valid,
  output logic [31:0]         ev_data,
  output logic                ev_last,
  input  logic                ev_ready,
  output logic                busy
);
  import dcache_pkg::*;

  localparam logic [OFF_BITS-1:0] CNT_MAX = '1;

  dcache_arr_state_t   state;
  logic [OFF_BITS-1:0] cnt;
  logic [WAY_BITS-1:0] way_q;
  logic [SET_BITS-1:0] index_q;

  logic                 idle;
  logic                 fill_beat;
  logic                 fill_final;
  logic [ADDR_BITS-1:0] raddr;
  logic [ADDR_BITS-1:0] waddr;
  logic [3:0]           wstrb;
  logic [31:0]          wdata;
  logic [WAYS-1:0]      we;
  logic [WAYS*32-1:0]   ram_rdata;

  assign idle       = (state == ST_IDLE);
  assign fill_beat  = (state == ST_FILL) && fill_valid;
  assign fill_final = fill_beat && (fill_last || (cnt == CNT_MAX));

  // Outside IDLE the line engines own both ports; lookups and stores are dropped.
  assign raddr = idle ? {rd_index, rd_off} : {index_q, cnt};
  assign waddr = idle ? {st_index, st_off} : {index_q, cnt};
  assign wstrb = idle ? st_strb  : 4'hf;
  assign wdata = idle ? st_wdata : fill_data;

  always_comb begin
    we = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (idle) we[w] = st_en && (st_way == WAY_BITS'(w));
      else      we[w] = fill_beat && (way_q == WAY_BITS'(w));
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
      .clk   (clk),
      .we    (we[g]),
      .wstrb (wstrb),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (ram_rdata[g*32 +: 32])
    );
  end

  assign ev_data = ram_rdata[32*way_q +: 32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      way_q     <= '0;
      index_q   <= '0;
      rd_data   <= '0;
      fill_done <= 1'b0;
      ev_valid  <= 1'b0;
      ev_last   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_en) rd_data <= ram_rdata;
          if (ev_start) begin
            state    <= ST_EVICT;
            way_q    <= ev_way;
            index_q  <= ev_index;
            cnt      <= '0;
            busy     <= 1'b1;
            ev_valid <= 1'b1;
            ev_last  <= (CNT_MAX == '0);
          end else if (fill_start) begin
            state   <= ST_FILL;
            way_q   <= fill_way;
            index_q <= fill_index;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        ST_FILL: begin
          if (fill_beat) begin
            cnt <= cnt + 1'b1;
            if (fill_final) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              fill_done <= 1'b1;
            end
          end
        end
        ST_EVICT: begin
          if (ev_ready) begin
            if (ev_last) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              ev_valid <= 1'b0;
              ev_last  <= 1'b0;
            end else begin
              cnt     <= cnt + 1'b1;
              ev_last <= (cnt == CNT_MAX - 1'b1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_data_array.sv
// Randomized bench for dcache_data_array against a per-word array model of the cache contents.
module tb_dcache_data_array;
  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [6:0]  rd_index;
  logic [2:0]  rd_off;
  logic [63:0] rd_data;
  logic        st_en;
  logic        st_way;
  logic [6:0]  st_index;
  logic [2:0]  st_off;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic        fill_start;
  logic        fill_way;
  logic [6:0]  fill_index;
  logic        fill_valid;
  logic [31:0] fill_data;
  logic        fill_last;
  logic        fill_done;
  logic        ev_start;
  logic        ev_way;
  logic [6:0]  ev_index;
  logic        ev_valid;
  logic [31:0] ev_data;
  logic        ev_last;
  logic        ev_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Contents of ways 0..1, sets 0..7, words 0..7 (the only region the bench touches).
  logic [31:0] model [2][8][8];

  dcache_data_array #(.WAYS(2), .SET_BITS(7), .OFF_BITS(3)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_index(rd_index), .rd_off(rd_off), .rd_data(rd_data),
    .st_en(st_en), .st_way(st_way), .st_index(st_index), .st_off(st_off),
    .st_strb(st_strb), .st_wdata(st_wdata),
    .fill_start(fill_start), .fill_way(fill_way), .fill_index(fill_index),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_last(fill_last),
    .fill_done(fill_done),
    .ev_start(ev_start), .ev_way(ev_way), .ev_index(ev_index),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_last(ev_last), .ev_ready(ev_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_en = 0; rd_index = '0; rd_off = '0;
    st_en = 0; st_way = 0; st_index = '0; st_off = '0; st_strb = '0; st_wdata = '0;
    fill_start = 0; fill_way = 0; fill_index = '0;
    fill_valid = 0; fill_data = '0; fill_last = 0;
    ev_start = 0; ev_way = 0; ev_index = '0; ev_ready = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic do_store(input logic w, input logic [2:0] idx, input logic [2:0] off,
                          input logic [3:0] strb, input logic [31:0] d);
    st_en = 1; st_way = w; st_index = {4'b0, idx}; st_off = off; st_strb = strb; st_wdata = d;
    step();
    st_en = 0;
    model[w][idx][off] = merge(model[w][idx][off], d, strb);
  endtask

  task automatic do_lookup(input string tag, input logic [2:0] idx, input logic [2:0] off);
    rd_en = 1; rd_index = {4'b0, idx}; rd_off = off;
    step();
    rd_en = 0;
    check(tag, rd_data, {model[1][idx][off], model[0][idx][off]});
  endtask

  task automatic do_store_lookup(input logic w, input logic [2:0] idx, input logic [2:0] off,
                                 input logic [3:0] strb, input logic [31:0] d);
    logic [63:0] exp;
    exp = {model[1][idx][off], model[0][idx][off]};
    st_en = 1; st_way = w; st_index = {4'b0, idx}; st_off = off; st_strb = strb; st_wdata = d;
    rd_en = 1; rd_index = {4'b0, idx}; rd_off = off;
    step();
    st_en = 0; rd_en = 0;
    check("read_first", rd_data, exp);
    model[w][idx][off] = merge(model[w][idx][off], d, strb);
  endtask

  task automatic check_line(input string tag, input logic [2:0] idx);
    for (int o = 0; o < 8; o++) do_lookup(tag, idx, 3'(o));
  endtask

  // n beats; the last one carries fill_last unless use_last is clear (n must then be 8).
  task automatic do_fill(input logic w, input logic [2:0] idx, input int n, input logic [31:0] base,
                         input bit use_last, input bit gaps, input bit poke_store);
    fill_start = 1; fill_way = w; fill_index = {4'b0, idx};
    step();
    fill_start = 0;
    check("fill_busy", 64'(busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        fill_valid = 0;
        step();
      end
      fill_valid = 1; fill_data = base + 32'(i); fill_last = use_last && (i == n - 1);
      if (poke_store) begin
        st_en = 1; st_way = w; st_index = {4'b0, idx}; st_off = 3'(i);
        st_strb = 4'hf; st_wdata = 32'hBAD0_0000;
      end
      step();
      model[w][idx][i] = base + 32'(i);
      check("fill_done", 64'(fill_done), 64'(i == n - 1));
      check("fill_busy_beat", 64'(busy), 64'(i != n - 1));
    end
    fill_valid = 0; fill_last = 0; st_en = 0;
    step();
    check("fill_done_once", 64'(fill_done), 64'd0);
  endtask

  // mode 0: ready always high, 1: toggling 1,0,1..., 2: random.
  task automatic do_evict(input logic w, input logic [2:0] idx, input int mode,
                          input bit both_start, input bit poke);
    int k = 0;
    int cyc = 0;
    bit tog = 1;
    bit r;
    ev_start = 1; ev_way = w; ev_index = {4'b0, idx};
    if (both_start) begin
      fill_start = 1; fill_way = ~w; fill_index = {4'b0, idx};
    end
    step();
    ev_start = 0; fill_start = 0;
    while (k < 8 && cyc < 64) begin
      check("ev_valid", 64'(ev_valid), 64'd1);
      check("ev_data", 64'(ev_data), 64'(model[w][idx][k]));
      check("ev_last", 64'(ev_last), 64'(k == 7));
      r = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      ev_ready = r;
      if (poke) begin
        fill_valid = 1; fill_data = $urandom; fill_last = 0;
        st_en = 1; st_way = ~w; st_index = {4'b0, idx}; st_off = 3'(k);
        st_strb = 4'hf; st_wdata = $urandom;
      end
      step();
      if (r) k++;
      cyc++;
    end
    ev_ready = 0; fill_valid = 0; st_en = 0;
    check("ev_count", 64'(k), 64'd8);
    check("ev_valid_end", 64'(ev_valid), 64'd0);
    check("ev_busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    #1;
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fill_done", 64'(fill_done), 64'd0);
    check("rst_ev_valid", 64'(ev_valid), 64'd0);
    check("rst_ev_last", 64'(ev_last), 64'd0);
    repeat (2) step();
    reset = 1;
    step();

    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++)
        do_fill(1'(w), 3'(s), 8, 32'h5000_0000 + 32'(w << 12) + 32'(s << 4), 1'b1, 1'b0, 1'b0);

    do_store(1'b1, 3'd5, 3'd2, 4'hf, 32'hDEADBEEF);
    do_lookup("lookup_store_full", 3'd5, 3'd2);
    check("lookup_way1", rd_data[63:32], 64'hDEADBEEF);

    do_store(1'b0, 3'd4, 3'd1, 4'hf, 32'h11223344);
    do_store(1'b0, 3'd4, 3'd1, 4'b0100, 32'h00AB0000);
    do_lookup("lookup_byte", 3'd4, 3'd1);
    check("byte_merge", rd_data[31:0], 64'h11AB3344);
    do_store(1'b0, 3'd4, 3'd6, 4'hf, 32'h11223344);
    do_store_lookup(1'b0, 3'd4, 3'd6, 4'b0100, 32'h00AB0000);
    do_store(1'b0, 3'd4, 3'd6, 4'b0000, 32'hFFFFFFFF);
    do_lookup("strb_zero_noop", 3'd4, 3'd6);

    do_fill(1'b0, 3'd3, 8, 32'h100, 1'b1, 1'b0, 1'b0);
    check_line("refill_line", 3'd3);
    do_evict(1'b0, 3'd3, 1, 1'b0, 1'b0);

    do_fill(1'b1, 3'd2, 8, 32'h200, 1'b0, 1'b1, 1'b1);
    check_line("refill_cnt_final", 3'd2);
    do_fill(1'b1, 3'd7, 3, 32'h700, 1'b1, 1'b1, 1'b0);
    check_line("refill_short", 3'd7);

    do_evict(1'b1, 3'd3, 0, 1'b1, 1'b1);
    check_line("evict_priority", 3'd3);

    fill_start = 1; fill_way = 1'b1; fill_index = 7'd6;
    step();
    fill_start = 0;
    for (int i = 0; i < 3; i++) begin
      fill_valid = 1; fill_data = 32'h300 + 32'(i);
      step();
      model[1][6][i] = 32'h300 + 32'(i);
    end
    fill_valid = 0;
    reset = 0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rd_data", rd_data, 64'd0);
    check("mid_rst_fill_done", 64'(fill_done), 64'd0);
    check("mid_rst_ev_valid", 64'(ev_valid), 64'd0);
    step();
    reset = 1;
    step();
    check_line("after_reset_line", 3'd6);

    for (int op = 0; op < 80; op++) begin
      logic        w;
      logic [2:0]  idx;
      logic [2:0]  off;
      int          n;
      w   = 1'($urandom_range(0, 1));
      idx = 3'($urandom_range(0, 7));
      off = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_store(w, idx, off, 4'($urandom_range(0, 15)), $urandom);
        4, 5, 6:    do_lookup("rand_lookup", idx, off);
        7: begin
          n = $urandom_range(1, 8);
          do_fill(w, idx, n, $urandom, (n < 8) || 1'($urandom_range(0, 1)), 1'b1,
                  1'($urandom_range(0, 1)));
        end
        8:       do_evict(w, idx, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: do_store_lookup(w, idx, off, 4'($urandom_range(0, 15)), $urandom);
      endcase
    end
    for (int s = 0; s < 8; s++) check_line("final_sweep", 3'(s));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
